// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with the HI/LO register pair.
//
// Executes mult/multu (MULT_CYCLES) and div/divu (DIV_CYCLES) from latched
// operands under a start/busy handshake, plus single-cycle mthi/mtlo.
// Optional feature macro: MD_UNIT_MADD_EN adds madd/maddu/msub/msubu
// (mdop 7..10), which accumulate into {hi,lo} and use MULT_CYCLES.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, clears all state
//   a, b   in   rs/rt operands (32 bits)
//   mdop   in   operation code (4 bits)
//   start  in   one-cycle pulse launching a multi-cycle op
//   busy   out  high while an operation is in flight
//   hi, lo out  HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  mdop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_LD = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_LD  = DIV_CYCLES[3:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [31:0] hi_q, lo_q, a_q, b_q;
    logic [3:0]  op_q, cnt_q;

    // Launch decode: which mdop values start a multi-cycle op, and for how long.
    logic       is_md;
    logic [3:0] cnt_ld;
    always_comb begin
        is_md  = 1'b0;
        cnt_ld = MULT_LD;
        case (mdop)
            OP_MULT, OP_MULTU: is_md = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_md  = 1'b1;
                cnt_ld = DIV_LD;
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_md = 1'b1;
`endif
            default: ;
        endcase
    end

    // Products from latched operands (64-bit context, explicit extension).
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of overflowing. Divisor forced to 1 on zero; result discarded.
    logic        b_nz, a_neg, b_neg;
    logic [31:0] b_safe, ua, ub, sq, sr, uq, ur;
    assign b_nz   = (b_q != 32'd0);
    assign b_safe = b_nz ? b_q : 32'd1;
    assign a_neg  = a_q[31];
    assign b_neg  = b_q[31];
    assign ua     = a_neg ? (32'd0 - a_q) : a_q;
    assign ub     = b_neg ? (32'd0 - b_safe) : b_safe;
    assign sq     = ua / ub;
    assign sr     = ua % ub;
    assign uq     = a_q / b_safe;
    assign ur     = a_q % b_safe;

    // Value committed to {hi,lo} on the final RUN edge.
    logic [31:0] hi_d, lo_d;
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: if (b_nz) begin
                lo_d = (a_neg ^ b_neg) ? (32'd0 - sq) : sq;
                hi_d = a_neg ? (32'd0 - sr) : sr;
            end
            OP_DIVU: if (b_nz) begin
                lo_d = uq;
                hi_d = ur;
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && is_md) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= mdop;
                        cnt_q   <= cnt_ld;
                        state_q <= RUN;
                    end else if (!start) begin
                        if (mdop == OP_MTHI) hi_q <= a;
                        else if (mdop == OP_MTLO) lo_q <= a;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected {hi,lo,busy length}
// from a longint reference model; a negedge monitor pops on each busy fall.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  mdop;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .mdop(mdop),
        .start(start), .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Architectural reference: returns busy length n (0 = no multi-cycle op).
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   inout logic [31:0] h, inout logic [31:0] l, output int n);
        longint      sx, sy, q, r;
        logic [63:0] pu, acc;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        pu  = {32'd0, x} * {32'd0, y};
        acc = {h, l};
        n   = 0;
        case (op)
            4'd1: begin {h, l} = sx * sy; n = 5; end
            4'd2: begin {h, l} = pu; n = 5; end
            4'd3: begin
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[31:0];
                    h = r[31:0];
                end
                n = 10;
            end
            4'd4: begin
                if (y != 0) begin
                    l = x / y;
                    h = x % y;
                end
                n = 10;
            end
            4'd5: h = x;
            4'd6: l = x;
`ifdef MD_UNIT_MADD_EN
            4'd7:  begin {h, l} = acc + 64'(sx * sy); n = 5; end
            4'd8:  begin {h, l} = acc + pu; n = 5; end
            4'd9:  begin {h, l} = acc - 64'(sx * sy); n = 5; end
            4'd10: begin {h, l} = acc - pu; n = 5; end
`endif
            default: ;
        endcase
    endfunction

    // Monitor: counts busy cycles, checks result and length when busy falls.
    initial begin
        int   len;
        bit   prev;
        exp_t e;
        len  = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 0;
                len  = 0;
            end else if (busy) begin
                if (!prev) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL busy_rise: got busy=1 with no op pending, expected busy=0");
                    end
                end
                prev = 1;
                len++;
            end else if (prev) begin
                prev = 0;
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("result_hi", {32'd0, hi}, {32'd0, e.hi});
                    check("result_lo", {32'd0, lo}, {32'd0, e.lo});
                    check("busy_len", 64'(len), 64'(e.len));
                end
                len = 0;
            end
        end
    end

    // Drive one op at posedge+1; returns at posedge+1 after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int          n;
        logic [31:0] h, l;
        h = mhi;
        l = mlo;
        ref_op(op, x, y, h, l, n);
        a     = x;
        b     = y;
        mdop  = op;
        start = ((op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10));
        if (n > 0) sbq.push_back('{h, l, n});
        mhi = h;
        mlo = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 4'd0;
        if (n == 0) check("single_cycle_hilo", {hi, lo}, {mhi, mlo});
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected busy=0", k);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        issue(op, x, y);
        wait_idle();
    endtask

    initial begin
        exp_t dummy;
        reset = 1'b1;
        a     = '0;
        b     = '0;
        mdop  = '0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {31'd0, busy, hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(4'd5, 32'h11, 32'd0);
        do_op(4'd6, 32'h22, 32'd0);
        do_op(4'd4, 32'h1234, 32'd0);
        check("divu_by_zero", {hi, lo}, 64'h0000_0011_0000_0022);

        // Inputs during RUN are ignored (mtlo, then a second start)
        issue(4'd1, 32'hFFFF_1234, 32'h0000_5678);
        @(posedge clk); #1;
        mdop = 4'd6; a = 32'h55; start = 1'b0;
        @(posedge clk); #1;
        mdop = 4'd2; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        mdop = 4'd0; start = 1'b0;
        wait_idle();
        check("run_ignores", {hi, lo}, {mhi, mlo});

        // Back-to-back: second start in the first idle cycle
        issue(4'd1, 32'd6, 32'hFFFF_FFF9);
        wait_idle();
        do_op(4'd2, 32'd100, 32'd200);
        check("back_to_back", {hi, lo}, 64'd20000);

        // Reset mid-RUN aborts the op
        issue(4'd1, 32'd3, 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        dummy = sbq.pop_back();
        mhi = 32'd0;
        mlo = 32'd0;
        #1;
        check("reset_abort", {31'd0, busy, hi, lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_commit_after_reset", {31'd0, busy, hi, lo}, 64'd0);

        // Accumulate ops (reference follows the macro)
        do_op(4'd5, 32'd0, 32'd0);
        do_op(4'd6, 32'd10, 32'd0);
        do_op(4'd7, 32'd2, 32'd3);
`ifdef MD_UNIT_MADD_EN
        check("madd_2x3", {hi, lo}, 64'd16);
`else
        check("madd_disabled", {hi, lo}, 64'd10);
`endif

        // Randomized ops, with occasional zero and small divisors
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 9));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            do_op(op, x, y);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline, alongside the combinational ALU. It owns the HI/LO register pair and executes mult/multu/div/divu with a fixed-latency start/busy handshake. It also executes mthi/mtlo single-cycle writes and exposes HI/LO for mfhi/mflo. The hazard unit stalls D while `start | busy` is high and an MD-class instruction sits in D.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- mdop  input  4  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7–10 madd/maddu/msub/msubu, see Configuration
  - 11–15 none
- start  input  1  one-cycle pulse with mdop 1–4 (or 7–10) in E.
- busy  output  1  high while an operation is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- State: `hi`, `lo`, operand latches `a_q`/`b_q`/`op_q`, down-counter `cnt` (4 bits), `busy` flag.
- Two states:
  - IDLE (`busy=0`)
  - RUN (`busy=1`, `cnt` ≠ 0)
- IDLE, `start=1` with a valid mult/div op:
  - latch a, b and mdop.
  - load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - go to RUN.
- IDLE, `start=0`, mdop=5: `hi<=a`. mdop=6: `lo<=a`. Other mdop values: no state change.
- `start=1` with a non-mult/div mdop: ignored; no state change.
- RUN:
  - `cnt` decrements every edge.
  - On the edge where `cnt` goes 1→0: commit the result to HI/LO, clear `busy`, return to IDLE.
- Inputs in RUN: `start`, mthi and mtlo are ignored; HI/LO stay unchanged until commit.
- Arithmetic (results computed from the latched operands):
  - mult: `{hi,lo} = $signed(a_q)*$signed(b_q)`, full 64 bits.
  - multu: same, unsigned.
  - div:
    - `lo` = signed quotient, truncated toward zero.
    - `hi` = remainder, with the sign of the dividend.
    - `0x80000000 / 0xFFFFFFFF` gives `lo=0x80000000`, `hi=0`.
  - divu: unsigned quotient in `lo`, remainder in `hi`.
  - Divide by zero (b_q=0): operation still runs the full DIV_CYCLES with `busy` high; HI/LO left unchanged at commit.

## Timing
- Reset values:
  - `hi=0`, `lo=0`, `busy=0`, `cnt=0`.
  - Operand latches cleared.
- `start` sampled at edge k; `busy=1` from after edge k through edge k+N, where N = MULT_CYCLES or DIV_CYCLES.
  - `busy` is high for exactly N cycles.
  - New HI/LO are visible in the first cycle `busy=0`.
- mthi/mtlo: `hi`/`lo` update at the same edge they are sampled (1-cycle latency).
- Back-to-back: `start` in the first cycle after `busy` falls is accepted; no dead cycle.
- Reset asserted mid-RUN: operation aborted immediately, result discarded, all registers return to reset values.
- `busy` and `hi`/`lo` are registered outputs; nothing combinational from inputs to outputs.

## Configuration
- `MD_UNIT_MADD_EN` defined:
  - mdop 7 (madd) and 8 (maddu) accumulate: `{hi,lo} += product`, signed and unsigned respectively.
  - mdop 9 (msub) and 10 (msubu) subtract: `{hi,lo} -= product`.
  - All four use MULT_CYCLES and the `{hi,lo}` value at commit time.
  - Wrap modulo 2^64.
- Undefined: mdop 7–10 behave as none; `start` with them is ignored; no accumulate logic is synthesized.

## Test plan
- multu a=0xFFFFFFFF b=0xFFFFFFFF, start pulse -> `busy` high exactly 5 cycles; then `hi=0xFFFFFFFE`, `lo=0x00000001`.
- div a=0xFFFFFFF9 (-7) b=2 -> after 10 cycles `lo=0xFFFFFFFD` (-3), `hi=0xFFFFFFFF` (-1). div a=0x80000000 b=0xFFFFFFFF -> `lo=0x80000000`, `hi=0`.
- Preload via mthi 0x11 and mtlo 0x22; then divu b=0 -> `busy` high 10 cycles; `hi=0x11`, `lo=0x22` unchanged.
- mult running:
  - mtlo 0x55 and a second start in cycle 2 -> both ignored; final HI/LO equal the first mult's product.
  - start on the cycle after `busy` falls -> accepted.
- mult 3×4 started, reset pulsed in cycle 3 -> `busy=0`, `hi=lo=0` immediately; no commit afterwards.
- With `MD_UNIT_MADD_EN`: mtlo 10, then madd a=2 b=3 -> `lo=16`, `hi=0`. Without the macro: same sequence -> `lo=10`, `busy` never asserted.
